ram_cmd_arbiter: RTL and testbench

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

---
 rtl/ram_cmd_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that serialises read/write transactions
// into a command-word RAM interface, with a bounded wait for read data.
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_SIZE-1:0] addr,
  input  logic [2*ADDR_SIZE-1:0] wdata,
  output logic [1:0]             done,
  output logic [1:0]             err,
  output logic [ADDR_SIZE-1:0]   rdata,
  output logic                   busy,
  output logic [ADDR_SIZE+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic                   ram_tx_valid,
  input  logic [ADDR_SIZE-1:0]   ram_dout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WR    = 3'd2,
    S_RD    = 3'd3,
    S_RWAIT = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   gnt_r;
  logic                   last_r;
  logic                   we_r;
  logic [ADDR_SIZE-1:0]   addr_r;
  logic [ADDR_SIZE-1:0]   wdata_r;
  logic [CNT_W-1:0]       cnt_r;

  logic                   pick_s;
  logic                   take_s;
  logic                   sel_we_s;
  logic [ADDR_SIZE-1:0]   sel_addr_s;
  logic [ADDR_SIZE-1:0]   sel_wdata_s;
  logic                   rx_hit_s;
  logic                   to_s;
  logic                   cmd_we_s;
  logic [ADDR_SIZE-1:0]   cmd_addr_s;
  logic                   rx_next_s;
  logic [ADDR_SIZE+1:0]   din_next_s;
  logic [1:0]             done_next_s;
  logic [1:0]             err_next_s;
  logic [ADDR_SIZE-1:0]   rdata_next_s;
  logic                   busy_next_s;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    pick_s = 1'b0;
    if (req == 2'b11) begin
      pick_s = ~last_r;
    end else if (req[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      sel_we_s    = we[1];
      sel_addr_s  = addr[2*ADDR_SIZE-1:ADDR_SIZE];
      sel_wdata_s = wdata[2*ADDR_SIZE-1:ADDR_SIZE];
    end else begin
      sel_we_s    = we[0];
      sel_addr_s  = addr[ADDR_SIZE-1:0];
      sel_wdata_s = wdata[ADDR_SIZE-1:0];
    end
  end

  assign take_s   = (state_r == S_IDLE) && (req != 2'b00);
  assign rx_hit_s = (state_r == S_RWAIT) && ram_tx_valid;
  assign to_s     = (state_r == S_RWAIT) && !ram_tx_valid && (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_next_s = take_s ? S_ADDR : S_IDLE;
      S_ADDR:  state_next_s = we_r ? S_WR : S_RD;
      S_WR:    state_next_s = S_RESP;
      S_RD:    state_next_s = S_RWAIT;
      S_RWAIT: state_next_s = (rx_hit_s || to_s) ? S_RESP : S_RWAIT;
      S_RESP:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Transaction context is frozen at grant so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_SIZE{1'b0}};
      wdata_r <= {ADDR_SIZE{1'b0}};
    end else if (take_s) begin
      gnt_r   <= pick_s;
      last_r  <= pick_s;
      we_r    <= sel_we_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
    end else begin
      gnt_r   <= gnt_r;
      last_r  <= last_r;
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Read-wait counter, restarted by the read-data command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_RD) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == S_RWAIT) && !ram_tx_valid) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // without adding latency; in IDLE the address comes straight from the pick.
  always_comb begin
    cmd_we_s    = (state_r == S_IDLE) ? sel_we_s : we_r;
    cmd_addr_s  = (state_r == S_IDLE) ? sel_addr_s : addr_r;
    rx_next_s   = 1'b0;
    din_next_s  = {(ADDR_SIZE+2){1'b0}};
    case (state_next_s)
      S_ADDR: begin
        rx_next_s  = 1'b1;
        din_next_s = {(cmd_we_s ? 2'b00 : 2'b10), cmd_addr_s};
      end
      S_WR: begin
        rx_next_s  = 1'b1;
        din_next_s = {2'b01, wdata_r};
      end
      S_RD: begin
        rx_next_s  = 1'b1;
        din_next_s = {2'b11, {ADDR_SIZE{1'b0}}};
      end
      default: begin
        rx_next_s  = 1'b0;
        din_next_s = {(ADDR_SIZE+2){1'b0}};
      end
    endcase
    if (state_next_s == S_RESP) begin
      done_next_s = gnt_r ? 2'b10 : 2'b01;
    end else begin
      done_next_s = 2'b00;
    end
    if (to_s) begin
      err_next_s = gnt_r ? 2'b10 : 2'b01;
    end else begin
      err_next_s = 2'b00;
    end
    if (rx_hit_s) begin
      rdata_next_s = ram_dout;
    end else if (to_s) begin
      rdata_next_s = {ADDR_SIZE{1'b0}};
    end else begin
      rdata_next_s = rdata;
    end
    busy_next_s = (state_next_s != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_rx_valid <= 1'b0;
      ram_din      <= {(ADDR_SIZE+2){1'b0}};
      done         <= 2'b00;
      err          <= 2'b00;
      rdata        <= {ADDR_SIZE{1'b0}};
      busy         <= 1'b0;
    end else begin
      ram_rx_valid <= rx_next_s;
      ram_din      <= din_next_s;
      done         <= done_next_s;
      err          <= err_next_s;
      rdata        <= rdata_next_s;
      busy         <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: transaction-timeline model, behavioural RAM,
// per-cycle compare plus hand-computed scenario checks.
module tb_ram_cmd_arbiter;

  localparam int TIMEOUT = 4;
  localparam int MAXC    = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, done, err;
  logic [15:0] addr, wdata;
  logic [7:0]  rdata, ram_dout;
  logic        busy, ram_rx_valid, ram_tx_valid;
  logic [9:0]  ram_din;

  always #5 clk = ~clk;

  ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .ram_din(ram_din),
    .ram_rx_valid(ram_rx_valid), .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_lat  = 1;
  bit noise   = 1'b0;

  // Expected outputs per cycle index
  logic [9:0] e_din   [0:MAXC];
  logic       e_rx    [0:MAXC];
  logic [1:0] e_done  [0:MAXC];
  logic [1:0] e_err   [0:MAXC];
  logic       e_busy  [0:MAXC];
  logic       e_rdset [0:MAXC];
  logic [7:0] e_rdval [0:MAXC];
  logic       e_wen   [0:MAXC];
  logic [7:0] e_wa    [0:MAXC];
  logic [7:0] e_wd    [0:MAXC];
  logic [7:0] mmem    [0:255];
  logic [7:0] rmem    [0:255];
  logic [7:0] hold;
  int         free_at = 0;
  logic       last    = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: on each sampled grant, lay out the whole transaction on the timeline.
  initial begin : model_proc
    int c, resp;
    logic g, w, e;
    logic [7:0] a, d, v;
    forever begin
      @(posedge clk);
      c = cyc;
      if (!rst_n) begin
        for (int k = c + 1; k <= MAXC; k++) begin
          e_din[k] = 10'd0; e_rx[k] = 1'b0; e_done[k] = 2'b00; e_err[k] = 2'b00;
          e_busy[k] = 1'b0; e_rdset[k] = 1'b0; e_rdval[k] = 8'h00; e_wen[k] = 1'b0;
          e_wa[k] = 8'h00; e_wd[k] = 8'h00;
        end
        e_rdset[c+1] = 1'b1;
        e_rdval[c+1] = 8'h00;
        free_at = c + 1;
        last = 1'b1;
      end else if (c >= free_at && req != 2'b00 && c + 16 < MAXC) begin
        g = (req == 2'b11) ? ~last : req[1];
        last = g;
        w = g ? we[1] : we[0];
        a = g ? addr[15:8] : addr[7:0];
        d = g ? wdata[15:8] : wdata[7:0];
        e_rx[c+1] = 1'b1; e_busy[c+1] = 1'b1; e_din[c+1] = {(w ? 2'b00 : 2'b10), a};
        e_rx[c+2] = 1'b1; e_busy[c+2] = 1'b1;
        if (w) begin
          e_din[c+2] = {2'b01, d};
          e_wen[c+2] = 1'b1; e_wa[c+2] = a; e_wd[c+2] = d;
          resp = c + 3;
          e = 1'b0;
        end else begin
          e_din[c+2] = 10'h300;
          if (rd_lat <= TIMEOUT) begin
            resp = c + 3 + rd_lat; v = mmem[a]; e = 1'b0;
          end else begin
            resp = c + 3 + TIMEOUT; v = 8'h00; e = 1'b1;
          end
          for (int k = c + 3; k < resp; k++) e_busy[k] = 1'b1;
          e_rdset[resp] = 1'b1;
          e_rdval[resp] = v;
        end
        e_busy[resp] = 1'b1;
        e_done[resp] = g ? 2'b10 : 2'b01;
        e_err[resp]  = e ? (g ? 2'b10 : 2'b01) : 2'b00;
        free_at = resp + 1;
      end
      cyc = cyc + 1;
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (e_wen[cyc]) mmem[e_wa[cyc]] = e_wd[cyc];
        if (e_rdset[cyc]) hold = e_rdval[cyc];
        chk("ram_din", ram_din, e_din[cyc]);
        chk("ram_rx_valid", ram_rx_valid, e_rx[cyc]);
        chk("done", done, e_done[cyc]);
        chk("err", err, e_err[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("rdata", rdata, hold);
      end
    end
  end

  // Behavioural RAM: answers reads rd_lat cycles after the read-data command.
  initial begin : ram_proc
    int pend;
    logic [7:0] ra;
    bit tog;
    pend = 0; ra = 8'h00; tog = 1'b0;
    ram_tx_valid = 1'b0;
    ram_dout = 8'h00;
    forever begin
      @(negedge clk);
      ram_tx_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ram_tx_valid = 1'b1;
          ram_dout = rmem[ra];
        end
      end
      if (noise && pend == 0) begin
        tog = ~tog;
        if (tog) begin
          ram_tx_valid = 1'b1;
          ram_dout = 8'hEE;
        end
      end
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00, 2'b10: ra = ram_din[7:0];
          2'b01:        rmem[ra] = ram_din[7:0];
          default:      pend = (rd_lat <= 50) ? rd_lat : 0;
        endcase
      end
    end
  end

  task automatic wait_done(input logic [1:0] m);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((done & m) != 2'b00) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  task automatic txn(input logic [1:0] r, input logic [1:0] w, input logic [15:0] a,
                     input logic [15:0] d, input int lat);
    rd_lat = lat; req = r; we = w; addr = a; wdata = d;
    wait_done(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rd_at, done_at, n;
    logic [1:0] seq [0:2];
    logic [1:0] e_seen;
    logic [7:0] r_seen;
    bit found;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 8'h00;
      rmem[i] = 8'h00;
    end
    hold = 8'h00;
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din", ram_din, 10'h000);
    chk("rst_rdata", rdata, 8'h00);

    // Write 0xA5 to 0x3C from requester 0
    @(posedge clk); #1;
    rd_lat = 1; req = 2'b01; we = 2'b01; addr = 16'h003C; wdata = 16'h00A5;
    @(negedge clk); chk("wr_idle_rx", ram_rx_valid, 1'b0);
    @(negedge clk); chk("wr_addr_din", ram_din, 10'h03C); chk("wr_addr_rx", ram_rx_valid, 1'b1);
    @(negedge clk); chk("wr_data_din", ram_din, 10'h1A5);
    @(negedge clk); chk("wr_done", done, 2'b01);
    @(posedge clk); #1; req = 2'b00;

    // Read it back from requester 1
    req = 2'b10; we = 2'b00; addr = 16'h3C00; wdata = 16'h0000;
    @(negedge clk);
    @(negedge clk); chk("rd_addr_din", ram_din, 10'h23C);
    @(negedge clk); chk("rd_cmd_din", ram_din, 10'h300);
    @(negedge clk);
    @(negedge clk); chk("rd_done", done, 2'b10); chk("rd_rdata", rdata, 8'hA5); chk("rd_err", err, 2'b00);
    @(posedge clk); #1; req = 2'b00;

    // Inputs changed after grant must not matter
    rd_lat = 1; req = 2'b10; we = 2'b10; addr = 16'h4400; wdata = 16'h5A00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    we = 2'b00; addr = 16'hFFFF; wdata = 16'h0000;
    wait_done(2'b10);
    txn(2'b01, 2'b00, 16'h0044, 16'h0000, 2);

    // Read timeout: RAM never answers
    rd_lat = 99; req = 2'b10; we = 2'b00; addr = 16'h3C00;
    rd_at = -100; done_at = 0; e_seen = 2'b00; r_seen = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_rx_valid && ram_din == 10'h300) rd_at = i;
      if (done != 2'b00) begin
        done_at = i; e_seen = err; r_seen = rdata;
        break;
      end
    end
    chk("to_gap", done_at - rd_at, 5);
    chk("to_err", e_seen, 2'b10);
    chk("to_rdata", r_seen, 8'h00);
    @(posedge clk); #1; req = 2'b00;

    // Answer in the last allowed wait cycle, then a faster one
    txn(2'b01, 2'b00, 16'h003C, 16'h0000, TIMEOUT);
    txn(2'b10, 2'b00, 16'h4400, 16'h0000, 3);

    // Stray read-valid strobes outside the wait state
    noise = 1'b1;
    txn(2'b01, 2'b01, 16'h0010, 16'h0033, 1);
    repeat (3) @(posedge clk);
    #1 noise = 1'b0;
    @(posedge clk); #1;
    txn(2'b01, 2'b00, 16'h0010, 16'h0000, 1);

    // Round-robin with both requesters held
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    rd_lat = 1; req = 2'b11; we = 2'b11; addr = 16'h5511; wdata = 16'h6622;
    n = 0;
    for (int i = 0; i < 3; i++) seq[i] = 2'b00;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        seq[n] = done;
        n++;
      end
    end
    @(posedge clk); #1; req = 2'b00;
    chk("rr_count", n, 3);
    chk("rr_grant0", seq[0], 2'b01);
    chk("rr_grant1", seq[1], 2'b10);
    chk("rr_grant2", seq[2], 2'b01);

    // Reset during the write-data cycle
    @(posedge clk); #1;
    rd_lat = 1; req = 2'b01; we = 2'b01; addr = 16'h0077; wdata = 16'h0099;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ram_rx_valid && ram_din[9:8] == 2'b01) found = 1'b1;
    end
    chk("abort_wr_seen", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rx", ram_rx_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 2'b00);
    req = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;
    txn(2'b01, 2'b01, 16'h0077, 16'h0012, 1);
    txn(2'b10, 2'b00, 16'h7700, 16'h0000, 2);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
